// File: rtl/mmio_cmd_queue_pkg.sv
// mmio_pkg: shared definitions for the host MMIO command queue.
//   - register byte offsets, derived from the field widths
//   - QSTAT bit indices
//   - mmio_desc_t descriptor layout (default widths)
package mmio_pkg;

  localparam int unsigned DEF_HOST_DW = 8;
  localparam int unsigned DEF_ADDR_W  = 16;
  localparam int unsigned DEF_ARG_W   = 32;
  localparam int unsigned DEF_MMVR_W  = 64;

  localparam int unsigned REG_STATUS = 0;
  localparam int unsigned REG_QSTAT  = 1;
  localparam int unsigned REG_CMD    = 2;
  localparam int unsigned REG_ADDR   = 3;

  function automatic int unsigned reg_arg(int unsigned addr_w, int unsigned host_dw);
    return REG_ADDR + addr_w / host_dw;
  endfunction

  function automatic int unsigned reg_mmvr(int unsigned addr_w, int unsigned arg_w,
                                           int unsigned host_dw);
    return reg_arg(addr_w, host_dw) + arg_w / host_dw;
  endfunction

  // Offset of the doorbell byte (top MMVR lane).
  function automatic int unsigned reg_bell(int unsigned addr_w, int unsigned arg_w,
                                           int unsigned mmvr_w, int unsigned host_dw);
    return reg_mmvr(addr_w, arg_w, host_dw) + mmvr_w / host_dw - 1;
  endfunction

  localparam int unsigned QSTAT_LEVEL_MSB = 3;
  localparam int unsigned QSTAT_EMPTY     = 4;
  localparam int unsigned QSTAT_FULL      = 5;
  localparam int unsigned QSTAT_OVF       = 6;
  localparam int unsigned QSTAT_DRAINED   = 7;

  typedef struct packed {
    logic [DEF_HOST_DW-1:0] cmd;
    logic [DEF_ADDR_W-1:0]  addr;
    logic [DEF_ARG_W-1:0]   arg;
    logic [DEF_MMVR_W-1:0]  mmvr;
  } mmio_desc_t;

endpackage

// File: rtl/mmio_cmd_queue_desc_fifo.sv
// desc_fifo: synchronous show-ahead FIFO for command descriptors.
//   clk, rst          rising-edge clock, synchronous active-high reset
//   push, push_data   enqueue; accepted when not full, or when full with a pop
//   pop               dequeue head; ignored when empty
//   head              current head entry (valid when !empty)
//   full, empty       occupancy flags
//   level             entry count 0..DEPTH
module desc_fifo #(
  parameter int unsigned WIDTH = 120,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [3:0]       level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == 4'd0);
  assign full    = (level == 4'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) level <= level + 4'd1;
      else if (do_pop && !do_push) level <= level - 4'd1;
    end
  end

endmodule

// File: rtl/mmio_cmd_queue.sv
// mmio_cmd_queue: host MMIO front end that stages descriptors byte by byte and
// queues them for the NPU controller.
//   clk, rst        rising-edge clock, synchronous active-high reset
//   host_addr       register byte offset
//   host_wr_data    write data, host_wr_en write strobe
//   host_rd_data    combinational read data for host_addr
//   status_in       NPU status byte shown at STATUS
//   desc_valid      FIFO head valid; desc_ready pops when valid
//   desc_cmd/addr/arg/mmvr  head descriptor fields
//   irq             drained | ovf, present only when MMIO_IRQ_EN is defined
// Build option: MMIO_IRQ_EN adds the drained flag and the irq output.
module mmio_cmd_queue
  import mmio_pkg::*;
#(
  parameter int unsigned HOST_DW = 8,
  parameter int unsigned MMIO_AW = 8,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned ARG_W   = 32,
  parameter int unsigned MMVR_W  = 64,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MMIO_AW-1:0] host_addr,
  input  logic [HOST_DW-1:0] host_wr_data,
  input  logic               host_wr_en,
  output logic [HOST_DW-1:0] host_rd_data,
  input  logic [HOST_DW-1:0] status_in,
  output logic               desc_valid,
  input  logic               desc_ready,
  output logic [HOST_DW-1:0] desc_cmd,
  output logic [ADDR_W-1:0]  desc_addr,
  output logic [ARG_W-1:0]   desc_arg,
  output logic [MMVR_W-1:0]  desc_mmvr
`ifdef MMIO_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int unsigned ADDR_B   = ADDR_W / HOST_DW;
  localparam int unsigned ARG_B    = ARG_W / HOST_DW;
  localparam int unsigned MMVR_B   = MMVR_W / HOST_DW;
  localparam int unsigned OFF_ARG  = reg_arg(ADDR_W, HOST_DW);
  localparam int unsigned OFF_MMVR = reg_mmvr(ADDR_W, ARG_W, HOST_DW);
  localparam int unsigned OFF_BELL = reg_bell(ADDR_W, ARG_W, MMVR_W, HOST_DW);
  localparam int unsigned DESC_W   = HOST_DW + ADDR_W + ARG_W + MMVR_W;

  logic [31:0]         off;
  logic [HOST_DW-1:0]  cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ARG_W-1:0]    arg_q;
  logic [MMVR_W-1:0]   mmvr_q;
  logic [MMVR_W-1:0]   mmvr_next;
  logic [DESC_W-1:0]   push_data;
  logic [DESC_W-1:0]   head;
  logic                doorbell;
  logic                pop;
  logic                qstat_wr;
  logic                full;
  logic                empty;
  logic [3:0]          level;
  logic                ovf_q;
  logic                ovf_d;
  logic                drained;
  logic [HOST_DW-1:0]  qstat;

  assign off      = 32'(host_addr);
  assign doorbell = host_wr_en & (off == OFF_BELL);
  assign qstat_wr = host_wr_en & (off == REG_QSTAT);
  assign pop      = desc_valid & desc_ready;

  // The pushed descriptor must carry the doorbell byte being written this cycle.
  always_comb begin
    mmvr_next = mmvr_q;
    mmvr_next[MMVR_W-HOST_DW +: HOST_DW] = host_wr_data;
  end

  // Field order matches mmio_desc_t: {cmd, addr, arg, mmvr}.
  assign push_data = {cmd_q, addr_q, arg_q, mmvr_next};

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q  <= '0;
      addr_q <= '0;
      arg_q  <= '0;
      mmvr_q <= '0;
    end else if (host_wr_en) begin
      if (off == REG_CMD) cmd_q <= host_wr_data;
      for (int unsigned i = 0; i < ADDR_B; i++)
        if (off == REG_ADDR + i) addr_q[i*HOST_DW +: HOST_DW] <= host_wr_data;
      for (int unsigned i = 0; i < ARG_B; i++)
        if (off == OFF_ARG + i) arg_q[i*HOST_DW +: HOST_DW] <= host_wr_data;
      for (int unsigned i = 0; i < MMVR_B; i++)
        if (off == OFF_MMVR + i) mmvr_q[i*HOST_DW +: HOST_DW] <= host_wr_data;
    end
  end

  desc_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (doorbell),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign desc_valid = ~empty;
  assign {desc_cmd, desc_addr, desc_arg, desc_mmvr} = head;

  // Set beats clear when both happen in one cycle.
  assign ovf_d = (doorbell & full & ~pop) |
                 (ovf_q & ~(qstat_wr & host_wr_data[QSTAT_OVF]));

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

`ifdef MMIO_IRQ_EN
  logic drained_q;
  logic drained_d;

  // Drained only when the level actually goes 1 -> 0 (a same-cycle push keeps it at 1).
  assign drained_d = (pop & (level == 4'd1) & ~doorbell) |
                     (drained_q & ~(qstat_wr & host_wr_data[QSTAT_DRAINED]));

  always_ff @(posedge clk) begin
    if (rst) begin
      drained_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      drained_q <= drained_d;
      irq       <= drained_d | ovf_d;
    end
  end

  assign drained = drained_q;
`else
  assign drained = 1'b0;
`endif

  always_comb begin
    qstat                    = '0;
    qstat[QSTAT_LEVEL_MSB:0] = level;
    qstat[QSTAT_EMPTY]       = empty;
    qstat[QSTAT_FULL]        = full;
    qstat[QSTAT_OVF]         = ovf_q;
    qstat[QSTAT_DRAINED]     = drained;
  end

  always_comb begin
    host_rd_data = '0;
    if (off == REG_STATUS) host_rd_data = status_in;
    if (off == REG_QSTAT)  host_rd_data = qstat;
    if (off == REG_CMD)    host_rd_data = cmd_q;
    for (int unsigned i = 0; i < ADDR_B; i++)
      if (off == REG_ADDR + i) host_rd_data = addr_q[i*HOST_DW +: HOST_DW];
    for (int unsigned i = 0; i < ARG_B; i++)
      if (off == OFF_ARG + i) host_rd_data = arg_q[i*HOST_DW +: HOST_DW];
    for (int unsigned i = 0; i < MMVR_B; i++)
      if (off == OFF_MMVR + i) host_rd_data = mmvr_q[i*HOST_DW +: HOST_DW];
  end

endmodule

// File: tb/tb_mmio_cmd_queue.sv
// tb_mmio_cmd_queue: self-checking bench for mmio_cmd_queue (default widths).
// Define MMIO_IRQ_EN to exercise the irq build.
module tb_mmio_cmd_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned BELL  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  host_addr;
  logic [7:0]  host_wr_data;
  logic        host_wr_en;
  logic [7:0]  host_rd_data;
  logic [7:0]  status_in;
  logic        desc_valid;
  logic        desc_ready;
  logic [7:0]  desc_cmd;
  logic [15:0] desc_addr;
  logic [31:0] desc_arg;
  logic [63:0] desc_mmvr;
`ifdef MMIO_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  mmio_cmd_queue #(
    .HOST_DW (8),
    .MMIO_AW (8),
    .ADDR_W  (16),
    .ARG_W   (32),
    .MMVR_W  (64),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .host_addr    (host_addr),
    .host_wr_data (host_wr_data),
    .host_wr_en   (host_wr_en),
    .host_rd_data (host_rd_data),
    .status_in    (status_in),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_cmd     (desc_cmd),
    .desc_addr    (desc_addr),
    .desc_arg     (desc_arg),
    .desc_mmvr    (desc_mmvr)
`ifdef MMIO_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [31:0] arg;
    logic [63:0] mmvr;
  } desc_t;

  // Reference model: register file as a byte array, FIFO as a queue.
  desc_t      q[$];
  logic [7:0] stage[32];
  bit         ovf_m;
  bit         drained_m;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic desc_t model_desc();
    desc_t d;
    d.cmd = stage[2];
    for (int i = 0; i < 2; i++) d.addr[8*i +: 8] = stage[3 + i];
    for (int i = 0; i < 4; i++) d.arg[8*i +: 8]  = stage[5 + i];
    for (int i = 0; i < 8; i++) d.mmvr[8*i +: 8] = stage[9 + i];
    return d;
  endfunction

  function automatic logic [7:0] model_qstat();
    int n = q.size();
    return 8'(n) | ((n == 0) ? 8'h10 : 8'h00) | ((n == DEPTH) ? 8'h20 : 8'h00) |
           (ovf_m ? 8'h40 : 8'h00) | (drained_m ? 8'h80 : 8'h00);
  endfunction

  function automatic logic [7:0] model_reg(int a);
    if (a == 0) return status_in;
    if (a == 1) return model_qstat();
    if (a >= 2 && a <= 16) return stage[a];
    return 8'h00;
  endfunction

  task automatic model_step(bit r, bit we, int a, logic [7:0] d, bit ready);
    int  n0;
    bit  pop, bell, clr_o, clr_d, set_o, set_d;
    if (r) begin
      q.delete();
      foreach (stage[i]) stage[i] = 8'h00;
      ovf_m = 0;
      drained_m = 0;
      return;
    end
    n0    = q.size();
    pop   = ready && (n0 > 0);
    bell  = we && (a == BELL);
    clr_o = we && (a == 1) && d[6];
    clr_d = we && (a == 1) && d[7];
    set_o = 0;
    set_d = 0;
    if (we && a >= 2 && a <= 16) stage[a] = d;
    if (pop) void'(q.pop_front());
    if (bell) begin
      if (n0 < DEPTH || pop) q.push_back(model_desc());
      else set_o = 1;
    end
`ifdef MMIO_IRQ_EN
    set_d = pop && (n0 == 1) && !bell;
`endif
    ovf_m     = set_o || (ovf_m && !clr_o);
    drained_m = set_d || (drained_m && !clr_d);
  endtask

  task automatic read_reg(int a, output logic [7:0] d);
    host_wr_en = 1'b0;
    host_addr  = 8'(a);
    #1;
    d = host_rd_data;
  endtask

  task automatic check_outputs();
    logic [7:0] rd;
    int         a;
    check("desc_valid", desc_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("desc_cmd", desc_cmd, q[0].cmd);
      check("desc_addr", desc_addr, q[0].addr);
      check("desc_arg", desc_arg, q[0].arg);
      check("desc_mmvr", desc_mmvr, q[0].mmvr);
    end
    read_reg(1, rd);
    check("qstat", rd, model_qstat());
    a = int'($urandom_range(0, 24));
    read_reg(a, rd);
    check($sformatf("reg_%0d", a), rd, model_reg(a));
`ifdef MMIO_IRQ_EN
    check("irq", irq, ovf_m || drained_m);
`endif
  endtask

  task automatic cycle(bit r, bit we, int a, logic [7:0] d, bit ready);
    rst          = r;
    host_wr_en   = we;
    host_addr    = 8'(a);
    host_wr_data = d;
    desc_ready   = ready;
    model_step(r, we, a, d, ready);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    host_wr_en = 1'b0;
    check_outputs();
  endtask

  task automatic idle(bit ready);
    cycle(0, 0, 0, 8'h00, ready);
  endtask

  task automatic load(logic [7:0] c, logic [15:0] ad, logic [31:0] ag, logic [63:0] mv,
                      bit rdy_body, bit rdy_bell);
    cycle(0, 1, 2, c, rdy_body);
    for (int i = 0; i < 2; i++) cycle(0, 1, 3 + i, ad[8*i +: 8], rdy_body);
    for (int i = 0; i < 4; i++) cycle(0, 1, 5 + i, ag[8*i +: 8], rdy_body);
    for (int i = 0; i < 7; i++) cycle(0, 1, 9 + i, mv[8*i +: 8], rdy_body);
    cycle(0, 1, BELL, mv[63:56], rdy_bell);
  endtask

  task automatic load_rand(bit rdy_body, bit rdy_bell);
    load(8'($urandom), 16'($urandom), $urandom, {$urandom, $urandom}, rdy_body, rdy_bell);
  endtask

  logic [7:0] rd;

  initial begin
    rst = 1'b1; host_wr_en = 1'b0; host_addr = '0; host_wr_data = '0;
    desc_ready = 1'b0; status_in = 8'h00;
    ovf_m = 0; drained_m = 0;
    foreach (stage[i]) stage[i] = 8'h00;

    // Reset state
    cycle(1, 0, 0, 8'h00, 0);
    cycle(1, 0, 0, 8'h00, 0);
    check("rst_valid", desc_valid, 1'b0);
    check("rst_cmd", desc_cmd, 8'h00);
    check("rst_mmvr", desc_mmvr, 64'h0);
    read_reg(1, rd);
    check("rst_qstat", rd, 8'h10);

    // Single descriptor, visible the cycle after the doorbell
    load(8'h11, 16'h1234, 32'hDEADBEEF, 64'h0123456789ABCDEF, 0, 0);
    check("t1_valid", desc_valid, 1'b1);
    check("t1_cmd", desc_cmd, 8'h11);
    check("t1_addr", desc_addr, 16'h1234);
    check("t1_arg", desc_arg, 32'hDEADBEEF);
    check("t1_mmvr", desc_mmvr, 64'h0123456789ABCDEF);
    read_reg(1, rd);
    check("t1_qstat", rd, 8'h01);
    read_reg(16, rd);
    check("t1_stage_kept", rd, 8'h01);

    // Fill, overflow, clear ovf
    cycle(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) load_rand(0, 0);
    read_reg(1, rd);
    check("t2_full", rd, 8'h24);
    load_rand(0, 0);
    read_reg(1, rd);
    check("t2_ovf", rd, 8'h64);
    cycle(0, 1, 1, 8'h40, 0);
    read_reg(1, rd);
    check("t2_clr", rd, 8'h24);

    // Full + doorbell + pop in the same cycle
    load(8'h77, 16'h5555, 32'h01020304, 64'hFEDCBA9876543210, 0, 1);
    read_reg(1, rd);
    check("t3_level", rd, 8'h24);
    for (int i = 0; i < 4; i++) idle(1);
    read_reg(1, rd);
    check("t3_drained", rd[6:0], 7'h10);

    // Interleaved push/pop across pointer wrap
    for (int i = 0; i < 6; i++) begin
      load_rand(0, i[0]);
      if (i[0]) idle(1);
    end
    for (int i = 0; i < 8 && q.size() > 0; i++) idle(1);
    check("t4_empty", desc_valid, 1'b0);
    cycle(0, 1, 1, 8'hC0, 0);

    // STATUS reflection and unmapped offset
    status_in = 8'hA5;
    read_reg(0, rd);
    check("t5_status", rd, 8'hA5);
    read_reg(8'h20, rd);
    check("t5_unmapped", rd, 8'h00);
    cycle(0, 1, 8'h20, 8'hFF, 0);
    read_reg(8'h20, rd);
    check("t5_unmapped_wr", rd, 8'h00);

    // Drained / irq, then reset mid-queue
    load_rand(0, 0);
    idle(1);
`ifdef MMIO_IRQ_EN
    check("t6_irq_set", irq, 1'b1);
    read_reg(1, rd);
    check("t6_qstat_drained", rd, 8'h90);
    cycle(0, 1, 1, 8'h80, 0);
    check("t6_irq_clr", irq, 1'b0);
`else
    read_reg(1, rd);
    check("t6_qstat_noirq", rd, 8'h10);
`endif
    load_rand(0, 0);
    load_rand(0, 0);
    cycle(1, 0, 0, 8'h00, 0);
    check("t6_rst_valid", desc_valid, 1'b0);
    read_reg(1, rd);
    check("t6_rst_qstat", rd, 8'h10);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int a;
      status_in = 8'($urandom);
      a = ($urandom_range(0, 2) == 0) ? int'(BELL) : int'($urandom_range(0, 20));
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0, a, 8'($urandom),
            $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
